// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq_if
//  Description : Start/busy/done handshake and result bus of the sequential
//                binary-to-BCD converter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bin_to_bcd_seq_if #(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3
);
    logic                  start;
    logic [IN_WIDTH-1:0]   bin_in;
    logic                  busy;
    logic                  done;
    logic [DIGITS*4-1:0]   bcd;
    logic                  ovf;
    logic                  neg;

    modport master (
        output start, bin_in,
        input  busy, done, bcd, ovf, neg
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd, ovf, neg
    );
endinterface
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Double-dabble converter, one add-3/shift step per clock.
//                Define SIGNED_INPUT_EN to treat bin_in as two's complement.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    bin_to_bcd_seq_if.slave    bus
);

    localparam int c_BCD_W = DIGITS * 4;
    localparam int c_CNT_W = $clog2(IN_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t               r_state;
    logic [IN_WIDTH-1:0]  r_sr;
    logic [c_BCD_W-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_ovf_int;
    logic                 r_sign;
    logic                 r_busy;
    logic                 r_done;
    logic [c_BCD_W-1:0]   r_bcd;
    logic                 r_ovf;
    logic                 r_neg;

    logic [IN_WIDTH-1:0]  w_mag;
    logic                 w_sign;
    logic [c_BCD_W-1:0]   w_adj;

`ifdef SIGNED_INPUT_EN
    // Negating the most-negative value wraps to itself, which is the correct
    // unsigned magnitude 2^(IN_WIDTH-1).
    assign w_sign = bus.bin_in[IN_WIDTH-1];
    assign w_mag  = w_sign ? (-bus.bin_in) : bus.bin_in;
`else
    assign w_sign = 1'b0;
    assign w_mag  = bus.bin_in;
`endif

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign w_adj[gi*4 +: 4] = (r_acc[gi*4 +: 4] >= 4'd5) ?
                                  (r_acc[gi*4 +: 4] + 4'd3) : r_acc[gi*4 +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sr      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_int <= 1'b0;
            r_sign    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_neg     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_sr      <= w_mag;
                        r_sign    <= w_sign;
                        r_acc     <= '0;
                        r_ovf_int <= 1'b0;
                        r_cnt     <= c_CNT_W'(IN_WIDTH);
                        r_busy    <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // A digit carried out of the top nibble means the value
                    // needs more digits than this instance has.
                    r_acc <= {w_adj[c_BCD_W-2:0], r_sr[IN_WIDTH-1]};
                    r_sr  <= r_sr << 1;
                    if (w_adj[c_BCD_W-1]) begin
                        r_ovf_int <= 1'b1;
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    r_bcd   <= r_ovf_int ? '1 : r_acc;
                    r_ovf   <= r_ovf_int;
                    r_neg   <= r_sign;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.bcd  = r_bcd;
    assign bus.ovf  = r_ovf;
    assign bus.neg  = r_neg;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_bcd_seq
//  Description : Self-checking bench for bin_to_bcd_seq (3-digit and 2-digit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    typedef struct packed {
        logic [11:0] bcd;
        logic        ovf;
        logic        neg;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q3[$];
    exp_t q2[$];
    exp_t e3;
    exp_t e2;

    bin_to_bcd_seq_if #(.IN_WIDTH(8), .DIGITS(3)) if3 ();
    bin_to_bcd_seq_if #(.IN_WIDTH(8), .DIGITS(2)) if2 ();

    bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3)
    );

    bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] v, input int digits);
        exp_t e;
        int   mag;
        e   = '0;
        mag = int'(v);
`ifdef SIGNED_INPUT_EN
        if (v[7]) begin
            e.neg = 1'b1;
            mag   = 256 - int'(v);
        end
`endif
        if (mag >= 10 ** digits) begin
            e.ovf = 1'b1;
            for (int d = 0; d < digits; d++) e.bcd[d*4 +: 4] = 4'hF;
        end else begin
            for (int d = 0; d < digits; d++) begin
                e.bcd[d*4 +: 4] = 4'(mag % 10);
                mag = mag / 10;
            end
        end
        return e;
    endfunction

    // Scoreboards: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && if3.done) begin
            check("done3_expected", 32'(q3.size() != 0), 1);
            if (q3.size() != 0) begin
                e3 = q3.pop_front();
                check("bcd3", 32'(if3.bcd), 32'(e3.bcd));
                check("ovf3", 32'(if3.ovf), 32'(e3.ovf));
                check("neg3", 32'(if3.neg), 32'(e3.neg));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && if2.done) begin
            check("done2_expected", 32'(q2.size() != 0), 1);
            if (q2.size() != 0) begin
                e2 = q2.pop_front();
                check("bcd2", 32'(if2.bcd), 32'(e2.bcd));
                check("ovf2", 32'(if2.ovf), 32'(e2.ovf));
                check("neg2", 32'(if2.neg), 32'(e2.neg));
            end
        end
    end

    task automatic wait_done(input int sel);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = (sel == 3) ? if3.done : if2.done;
        end
        check("done_timeout", 32'(got), 1);
    endtask

    task automatic conv(input int sel, input logic [7:0] val);
        @(negedge clk);
        if (sel == 3) begin
            if3.bin_in = val;
            if3.start  = 1'b1;
            q3.push_back(model(val, 3));
        end else begin
            if2.bin_in = val;
            if2.start  = 1'b1;
            q2.push_back(model(val, 2));
        end
        @(negedge clk);
        if3.start = 1'b0;
        if2.start = 1'b0;
        wait_done(sel);
    endtask

    initial begin
        int nb;

        // Reset held while start is requested
        rst_n = 1'b0;
        if3.start = 1'b1; if3.bin_in = 8'd77;
        if2.start = 1'b1; if2.bin_in = 8'd5;
        repeat (3) @(negedge clk);
        check("rst_busy3", 32'(if3.busy), 0);
        check("rst_done3", 32'(if3.done), 0);
        check("rst_bcd3",  32'(if3.bcd),  0);
        check("rst_ovf3",  32'(if3.ovf),  0);
        check("rst_neg3",  32'(if3.neg),  0);
        check("rst_busy2", 32'(if2.busy), 0);
        check("rst_bcd2",  32'(if2.bcd),  0);
        if3.start = 1'b0;
        if2.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy3", 32'(if3.busy), 0);

        // 255: busy for IN_WIDTH+1 cycles, then a single-cycle done
        if3.bin_in = 8'd255;
        if3.start  = 1'b1;
        q3.push_back(model(8'd255, 3));
        @(negedge clk);
        if3.start = 1'b0;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            if (!if3.busy) break;
            nb++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(nb), 9);
        check("done_after_busy", 32'(if3.done), 1);
        @(negedge clk);
        check("done_one_cycle", 32'(if3.done), 0);
        check("bcd_hold", 32'(if3.bcd), 32'(model(8'd255, 3).bcd));

        conv(3, 8'd0);
        conv(3, 8'd9);
        conv(3, 8'd100);
        conv(2, 8'd99);
        conv(2, 8'd100);
        conv(2, 8'd0);
        conv(2, 8'd255);

        // Start and bin_in changes while busy are ignored
        @(negedge clk);
        if3.bin_in = 8'd123;
        if3.start  = 1'b1;
        q3.push_back(model(8'd123, 3));
        @(negedge clk);
        if3.start = 1'b0;
        repeat (2) @(negedge clk);
        if3.bin_in = 8'd200;
        if3.start  = 1'b1;
        @(negedge clk);
        if3.start  = 1'b0;
        if3.bin_in = 8'd7;
        wait_done(3);
        // Back-to-back start on the done cycle
        if3.bin_in = 8'd57;
        if3.start  = 1'b1;
        q3.push_back(model(8'd57, 3));
        @(negedge clk);
        if3.start = 1'b0;
        check("b2b_busy", 32'(if3.busy), 1);
        wait_done(3);

        // Reset during a conversion aborts it with no done
        @(negedge clk);
        if3.bin_in = 8'd200;
        if3.start  = 1'b1;
        @(negedge clk);
        if3.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(if3.busy), 0);
        check("abort_done", 32'(if3.done), 0);
        check("abort_bcd",  32'(if3.bcd),  0);
        check("abort_ovf",  32'(if3.ovf),  0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_bcd_after", 32'(if3.bcd), 0);
        conv(3, 8'd42);

        // Values with the MSB set exercise the signed path when enabled
        conv(3, 8'hF6);
        conv(3, 8'h80);
        conv(3, 8'h7F);
        conv(2, 8'hF6);
        conv(2, 8'h80);

        repeat (3) @(negedge clk);
        check("q3_drained", 32'(q3.size()), 0);
        check("q2_drained", 32'(q2.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
